// File: rtl/uart_tx_arbiter.sv
// Purpose: arbitrates two byte requesters onto one UART transmitter and handshakes each byte with txrdy.
// Latency: request and txrdy high at edge N -> tx_wr and ack during cycle N+1; tx_wr pulses are at least 4 cycles apart.
// Backpressure: no grant while txrdy is low or busy; waits for txrdy to fall then rise, aborts after TO_CYCLES (macro UART_TX_ARB_RR_EN = round-robin).
module uart_tx_arbiter #(
  parameter int unsigned TO_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  input  logic       txrdy,
  output logic       tx_wr,
  output logic [7:0] tx_data,
  output logic       grant_id,
  output logic       busy,
  output logic       to_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_RISE = 2'd3
  } state_t;

  // Counter value seen on the edge where it reaches TO_CYCLES.
  localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);

  state_t      state;
  logic [15:0] to_cnt;
  logic        txrdy_q;
  logic        win;
  logic        txrdy_rise;

  assign txrdy_rise = txrdy & ~txrdy_q;

  // Winner select: a lone requester always wins; contention resolved by build mode.
  always_comb begin
    win = 1'b0;
    if (!req0) begin
      win = 1'b1;
    end else if (!req1) begin
      win = 1'b0;
    end else begin
`ifdef UART_TX_ARB_RR_EN
      win = ~grant_id;
`else
      win = 1'b0;
`endif
    end
  end

  // Arbiter FSM with registered strobes, edge detect and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_wr    <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      to_err   <= 1'b0;
      busy     <= 1'b0;
      tx_data  <= 8'h00;
      grant_id <= 1'b1;
      txrdy_q  <= 1'b0;
      to_cnt   <= 16'd0;
    end else begin
      txrdy_q <= txrdy;
      tx_wr   <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      to_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (txrdy && (req0 || req1)) begin
            state    <= WRITE;
            tx_data  <= win ? data1 : data0;
            grant_id <= win;
            tx_wr    <= 1'b1;
            ack0     <= ~win;
            ack1     <= win;
            busy     <= 1'b1;
          end
        end
        WRITE: begin
          state  <= WAIT_LOW;
          to_cnt <= 16'd0;
        end
        WAIT_LOW, WAIT_RISE: begin
          to_cnt <= to_cnt + 16'd1;
          if (to_cnt == TO_LAST) begin
            // Timeout wins over any txrdy activity on the same edge.
            state  <= IDLE;
            busy   <= 1'b0;
            to_err <= 1'b1;
          end else if (state == WAIT_LOW) begin
            if (!txrdy) state <= WAIT_RISE;
          end else if (txrdy_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus randomized transfers against a transaction-level model.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Built with TO_CYCLES=8; contention expectations follow the UART_TX_ARB_RR_EN build.
module tb_uart_tx_arbiter;

  localparam int TOC = 8;

  logic       clk;
  logic       rst;
  logic       req0, req1, ack0, ack1;
  logic [7:0] data0, data1;
  logic       txrdy, tx_wr, grant_id, busy, to_err;
  logic [7:0] tx_data;

  int n_checks = 0;
  int n_errors = 0;

  // Model: last winner, used for round-robin contention.
  logic m_last;

  uart_tx_arbiter #(.TO_CYCLES(TOC)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .txrdy(txrdy), .tx_wr(tx_wr), .tx_data(tx_data),
    .grant_id(grant_id), .busy(busy), .to_err(to_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule: lone requester wins; contention per build mode.
  function automatic logic pick(input logic r0, input logic r1, input logic last);
    if (!r0) return 1'b1;
    if (!r1) return 1'b0;
`ifdef UART_TX_ARB_RR_EN
    return ~last;
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; txrdy = 1'b0;
    data0 = 8'h00; data1 = 8'h00;
    tick();
    rst = 1'b0;
    m_last = 1'b1;
  endtask

  // Present a request with txrdy high and check the grant cycle.
  task automatic do_grant(input logic r0, input logic r1, input logic [7:0] d0, input logic [7:0] d1);
    logic w;
    req0 = r0; req1 = r1; data0 = d0; data1 = d1; txrdy = 1'b1;
    tick();
    w = pick(r0, r1, m_last);
    m_last = w;
    chk("grant_tx_wr", 16'(tx_wr), 16'd1);
    chk("grant_ack0", 16'(ack0), 16'(!w));
    chk("grant_ack1", 16'(ack1), 16'(w));
    chk("grant_data", 16'(tx_data), 16'(w ? d1 : d0));
    chk("grant_id", 16'(grant_id), 16'(w));
    chk("grant_busy", 16'(busy), 16'd1);
  endtask

  // Cycle after WRITE: strobes gone, still busy.
  task automatic after_write(input bit noise);
    if (noise) begin
      req0 = 1'($urandom_range(0, 1)); req1 = 1'($urandom_range(0, 1));
      data0 = 8'($urandom); data1 = 8'($urandom);
    end
    tick();
    chk("wl_tx_wr", 16'(tx_wr), 16'd0);
    chk("wl_acks", 16'(ack0 | ack1), 16'd0);
    chk("wl_busy", 16'(busy), 16'd1);
  endtask

  // txrdy high h cycles, low l cycles, then high: transfer completes on that rise.
  task automatic finish_normal(input int h, input int l, input bit noise);
    after_write(noise);
    for (int j = 0; j <= h + l; j++) begin
      txrdy = (j < h || j == h + l) ? 1'b1 : 1'b0;
      if (noise) begin
        req0 = 1'($urandom_range(0, 1)); req1 = 1'($urandom_range(0, 1));
      end
      tick();
      chk("fin_busy", 16'(busy), 16'(j < h + l));
      chk("fin_tx_wr", 16'(tx_wr | ack0 | ack1), 16'd0);
      chk("fin_to_err", 16'(to_err), 16'd0);
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  // txrdy stays high, or falls after h cycles and never rises: timeout after TOC cycles.
  task automatic finish_timeout(input bit fall, input int h);
    after_write(1'b1);
    for (int k = 1; k <= TOC; k++) begin
      txrdy = (fall && (k - 1) >= h) ? 1'b0 : 1'b1;
      req0 = 1'($urandom_range(0, 1)); req1 = 1'($urandom_range(0, 1));
      tick();
      chk("to_err_pulse", 16'(to_err), 16'(k == TOC));
      chk("to_busy", 16'(busy), 16'(k != TOC));
      chk("to_tx_wr", 16'(tx_wr), 16'd0);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("to_err_once", 16'(to_err), 16'd0);
    chk("to_idle_busy", 16'(busy), 16'd0);
    chk("to_no_wr", 16'(tx_wr), 16'd0);
  endtask

  logic exp_seq [3];
  logic saw_wr;

  initial begin
    do_reset();
    chk("rst_tx_wr", 16'(tx_wr), 16'd0);
    chk("rst_ack", 16'({ack0, ack1}), 16'd0);
    chk("rst_to_err", 16'(to_err), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_tx_data", 16'(tx_data), 16'h00);
    chk("rst_grant_id", 16'(grant_id), 16'd1);

    // Single request from requester 0.
    do_grant(1'b1, 1'b0, 8'hA5, 8'h00);
    chk("first_data_a5", 16'(tx_data), 16'hA5);
    finish_normal(1, 1, 1'b0);

    // Held contention over three transfers from reset.
    do_reset();
`ifdef UART_TX_ARB_RR_EN
    exp_seq = '{1'b0, 1'b1, 1'b0};
`else
    exp_seq = '{1'b0, 1'b0, 1'b0};
`endif
    for (int t = 0; t < 3; t++) begin
      do_grant(1'b1, 1'b1, 8'h10 + 8'(t), 8'h20 + 8'(t));
      chk("contend_seq", 16'(grant_id), 16'(exp_seq[t]));
      req0 = 1'b1; req1 = 1'b1;
      finish_normal(0, 1, 1'b0);
    end

    // Timeout with txrdy held high.
    do_grant(1'b0, 1'b1, 8'h00, 8'h3C);
    finish_timeout(1'b0, 0);

    // Reset during WAIT_RISE aborts silently.
    do_grant(1'b1, 1'b0, 8'h77, 8'h00);
    req0 = 1'b0; txrdy = 1'b0;
    tick();
    tick();
    chk("wr_busy_pre_rst", 16'(busy), 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_last = 1'b1;
    chk("mid_rst_busy", 16'(busy), 16'd0);
    chk("mid_rst_data", 16'(tx_data), 16'h00);
    chk("mid_rst_gid", 16'(grant_id), 16'd1);
    chk("mid_rst_ack_err", 16'({ack0, ack1, to_err, tx_wr}), 16'd0);

    // Requester 1 waits 20 cycles for txrdy.
    req1 = 1'b1; data1 = 8'h5A; txrdy = 1'b0;
    saw_wr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_wr || ack1) saw_wr = 1'b1;
    end
    chk("no_wr_txrdy_low", 16'(saw_wr), 16'd0);
    do_grant(1'b0, 1'b1, 8'h00, 8'h5A);
    finish_normal(2, 2, 1'b1);

    // Randomized transfers.
    for (int it = 0; it < 40; it++) begin
      int k;
      logic r0, r1;
      k = $urandom_range(0, 3);
      for (int g = 0; g < k; g++) begin
        // Requests that vanish before txrdy rises are never served.
        txrdy = 1'b0;
        req0 = 1'($urandom_range(0, 1)); req1 = 1'($urandom_range(0, 1));
        tick();
        chk("ghost_no_wr", 16'(tx_wr | ack0 | ack1), 16'd0);
        chk("ghost_idle", 16'(busy), 16'd0);
      end
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      do_grant(r0, r1, 8'($urandom), 8'($urandom));
      case ($urandom_range(0, 3))
        0:       finish_timeout(1'b0, 0);
        1:       finish_timeout(1'b1, $urandom_range(0, 3));
        default: finish_normal($urandom_range(0, 2), $urandom_range(1, 3), 1'b1);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: TO_CYCLES, default 1023, cycles allowed in WAIT_LOW plus WAIT_RISE before timeout; legal range 2..65535.
REQ-002 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: req0  input  1  requester 0 holds a byte to send; level, held until ack0.
REQ-005 Port: data0  input  8  requester 0 byte; stable while req0 high.
REQ-006 Port: ack0  output  1  one-cycle pulse; data0 taken.
REQ-007 Port: req1 / data1 / ack1  as req0 / data0 / ack0 for requester 1.
REQ-008 Port: txrdy  input  1  transmitter ready level from the UART TX.
REQ-009 Port: tx_wr  output  1  one-cycle write strobe to the UART TX.
REQ-010 Port: tx_data  output  8  byte to the UART TX; valid when tx_wr high and held until the next grant.
REQ-011 Port: grant_id  output  1  index of the last granted requester.
REQ-012 Port: busy  output  1  high in every state except IDLE.
REQ-013 Port: to_err  output  1  one-cycle pulse on timeout.

Function
REQ-014 States: IDLE, WRITE, WAIT_LOW, WAIT_RISE; all outputs registered.
REQ-015 IDLE: if txrdy=1 and (req0|req1), select winner, latch its data into tx_data, set grant_id, go to WRITE; otherwise stay in IDLE.
REQ-016 WRITE lasts exactly one cycle: tx_wr=1 and ack of the winner=1; then go to WAIT_LOW.
REQ-017 Latency: request and txrdy sampled high at edge N -> tx_wr/ack high during cycle N+1.
REQ-018 WAIT_LOW: stay until txrdy=0, then go to WAIT_RISE.
REQ-019 WAIT_RISE: internal positive-edge detect (txrdy registered once; edge = txrdy & ~txrdy_q); on edge, go to IDLE.
REQ-020 Timeout counter: cleared on entry to WAIT_LOW; increments each cycle in WAIT_LOW/WAIT_RISE; on reaching TO_CYCLES -> to_err=1 for one cycle and return to IDLE.
REQ-021 A request dropped before grant is not served; no ack is issued for it.
REQ-022 Requests arriving while busy=1 are ignored until IDLE; no queuing inside the block.
REQ-023 Only one of ack0/ack1 is high in any cycle; ack only coincides with tx_wr.
REQ-024 Winner with both requests pending: per REQ-029/REQ-030.
REQ-025 Minimum spacing between two tx_wr pulses: 4 cycles (WRITE, WAIT_LOW, WAIT_RISE, IDLE).

Reset
REQ-026 rst=1 at a rising edge forces IDLE, tx_wr=0, ack0=0, ack1=0, to_err=0, busy=0, tx_data=8'h00, grant_id=1, txrdy_q=0, and timeout counter=0.
REQ-027 Reset mid-transfer aborts the transfer with no ack and no to_err; the first grant after reset follows REQ-015 normally.
REQ-028 The reset value grant_id=1 makes requester 0 win the first simultaneous contention in round-robin mode.

Configuration
REQ-029 Macro UART_TX_ARB_RR_EN defined: round-robin; on contention, the requester other than grant_id wins.
REQ-030 UART_TX_ARB_RR_EN undefined: fixed priority; req0 always wins contention; grant_id still reports the winner.

Verification
REQ-031 Reset, then txrdy=1, req0=1, data0=8'hA5 -> cycle N+1 tx_wr=1, ack0=1, tx_data=8'hA5, grant_id=0.
REQ-032 RR build: req0=req1=1 held, txrdy toggles each transfer -> tx_data alternates data0/data1, starting with data0.
REQ-033 Fixed build: req0=req1=1 held for 3 transfers -> all three acks are ack0; ack1 is never asserted.
REQ-034 TO_CYCLES=8; after tx_wr, hold txrdy=1 -> to_err pulse 8 cycles after WAIT_LOW entry, busy=0 on the next cycle, and no second tx_wr.
REQ-035 rst=1 during WAIT_RISE -> next cycle busy=0, tx_data=8'h00, and no ack or to_err.
REQ-036 txrdy=0 with req1=1 held for 20 cycles -> no tx_wr; raise txrdy -> tx_wr one cycle later with data1.
